hadamard_align_add: RTL and testbench
=====================================

// Module: hadamard_align_add
// PURPOSE
//  Upstream neighbour of fix2sfp in the Hadamard datapath.
//  - Takes one group of 4 SFP operands plus per-operand negate flags.
//  - Finds the group max exponent and aligns each significand to it as two's-complement fixed point.
//  - Sums the group; the sum and max_exp feed fix2sfp (fixin/max_exp) directly.
//  - 3-stage pipeline with valid/ready handshake.
// PARAMETERS
//  expWidth     4  exponent field width
//  sigWidth     4  stored significand width (hidden one implied)
//  formatWidth  9  SFP word = {sign, exp[expWidth-1:0], sig[sigWidth-1:0]}
//  low_expand   2  extra fraction bits kept below the significand LSB
//  FW (localparam) = sigWidth+4+low_expand (fixed-point output width; 10 by default)
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              asynchronous, active-high reset
//  in_valid     in   1              group valid
//  in_ready     out  1              block accepts group this cycle
//  in_data      in   4*formatWidth  operand k at [k*formatWidth +: formatWidth]
//  in_neg       in   4              bit k=1: subtract operand k
//  out_valid    out  1              result valid
//  out_ready    in   1              downstream accepts result
//  fix_out      out  FW             signed two's-complement sum (drives fix2sfp.fixin)
//  max_exp_out  out  expWidth       group max exponent (drives fix2sfp.max_exp)
// BEHAVIOUR
//  - Reset: all stage valids=0; out_valid=0; fix_out=0; max_exp_out=0. Reset mid-flight discards all groups in the pipe.
//  - Handshake:
//    - stall = out_valid & ~out_ready; in_ready = ~stall.
//    - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
//    - All stages advance together when ~stall (bubbles are not squeezed).
//    - Outputs hold stable while stalled.
//  - Latency: group accepted at cycle T appears at out_valid in cycle T+3 if there is no stall. Throughput: 1 group per cycle.
//  - S1 (register):
//    - Operand zero iff exp==0 && sig==0.
//    - M = max exp over nonzero operands (0 if all zero).
//    - eff_sign_k = sign_k ^ in_neg[k].
//  - S2 (align):
//    - mag_k = {1,sig_k} << low_expand, i.e. hidden one at bit sigWidth+low_expand.
//    - mag_k is then >> (M-exp_k), truncated.
//    - Shift > sigWidth+low_expand, or zero operand -> 0.
//    - Operand becomes FW-bit two's complement, negated when eff_sign_k=1.
//  - S3 (add):
//    - fix_out = sum of the 4 aligned values; max_exp_out = M.
//    - 2 guard bits make overflow impossible (|sum| <= 4*(2^(sigWidth+low_expand+1)-1)).
//  - Exactly-cancelling sums give fix_out=0; M is still reported.
// CONFIGURATION
//  - HADAMARD_ALIGN_RND_EN defined:
//    - S2 rounds half-up on magnitude: adds 1 when the most significant shifted-out bit is 1, then applies sign.
//    - Shift of exactly sigWidth+low_expand+1 rounds to 1.
//  - Undefined: pure truncation, as above. Latency and ports are identical either way.
// TESTING
//  - Four ops {0,5,0} (sign,exp,sig), in_neg=0 -> fix_out=0x100, max_exp_out=5, out_valid 3 cycles after accept.
//  - op0 {0,5,8}, op1 {0,5,8} with in_neg=4'b0010, op2/op3 zero -> fix_out=0x000, max_exp_out=5.
//  - op0 {1,5,0}, others zero -> fix_out=0x3C0 (-64), max_exp_out=5.
//  - op0 {0,9,0}, op1 {0,1,F} (shift 8>6), others zero -> fix_out=0x040, max_exp_out=9.
//  - op0 {0,6,0}, op1 {0,2,F}, others zero:
//    - macro undefined -> fix_out=0x047.
//    - HADAMARD_ALIGN_RND_EN defined -> fix_out=0x048.
//  - Stream 5 groups with out_ready low for 4 cycles mid-stream:
//    - in_ready=0 while stalled; no group is lost or duplicated; order is preserved.
//    - Assert rst mid-stream: out_valid=0 immediately; no stale result after release.

Source files
------------

// File: rtl/hadamard_align_add.sv
// Purpose : align a group of 4 SFP operands to their max exponent and sum them as fixed point.
// Latency : 3 cycles from accept to out_valid; one group per cycle throughput.
// Backpr. : whole pipe freezes while out_valid & ~out_ready; in_ready drops for that cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   group handshake; in_data holds operand k at [k*formatWidth +: formatWidth]
//   in_neg              bit k set subtracts operand k
//   out_valid/out_ready result handshake
//   fix_out             signed FW-bit sum (feeds fix2sfp.fixin)
//   max_exp_out         group max exponent (feeds fix2sfp.max_exp)
//
// Build option: define HADAMARD_ALIGN_RND_EN to round half-up on the aligned
// magnitude instead of truncating. Ports and latency are unchanged.

module hadamard_align_add #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 9,
  parameter int low_expand  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4*formatWidth-1:0]   in_data,
  input  logic [3:0]                 in_neg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [sigWidth+4+low_expand-1:0] fix_out,
  output logic [expWidth-1:0]        max_exp_out
);

  localparam int FW = sigWidth + 4 + low_expand;
  // Magnitude width: hidden one + stored significand + extra fraction bits.
  localparam int MW = sigWidth + 1 + low_expand;
`ifdef HADAMARD_ALIGN_RND_EN
  // A shift of exactly MW still leaves the hidden one as the rounding bit.
  localparam int MAX_SH = MW;
`else
  localparam int MAX_SH = MW - 1;
`endif

  logic advance;
  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // ---------------- S1: unpack, zero detect, max exponent ----------------
  logic [3:0]                in_sgn;
  logic [3:0]                in_zero;
  logic [3:0][expWidth-1:0]  in_exp;
  logic [3:0][sigWidth-1:0]  in_sig;
  logic [expWidth-1:0]       m_comb;

  always_comb begin
    m_comb  = '0;
    in_sgn  = '0;
    in_zero = '0;
    in_exp  = '0;
    in_sig  = '0;
    for (int k = 0; k < 4; k++) begin
      in_sgn[k]  = in_data[k*formatWidth + formatWidth - 1] ^ in_neg[k];
      in_exp[k]  = in_data[k*formatWidth + sigWidth +: expWidth];
      in_sig[k]  = in_data[k*formatWidth +: sigWidth];
      in_zero[k] = (in_exp[k] == '0) && (in_sig[k] == '0);
      // Zero operands must not pull the max exponent.
      if (!in_zero[k] && (in_exp[k] > m_comb))
        m_comb = in_exp[k];
    end
  end

  logic                      s1_vld;
  logic [expWidth-1:0]       s1_max;
  logic [3:0]                s1_sgn;
  logic [3:0]                s1_zero;
  logic [3:0][expWidth-1:0]  s1_exp;
  logic [3:0][sigWidth-1:0]  s1_sig;

  // ---------------- S2: align and convert to two's complement ----------------
  logic [3:0][FW-1:0]        aligned;
  logic [expWidth-1:0]       sh;
  logic [MW-1:0]             mag;
  logic [FW-1:0]             mag_ext;
`ifdef HADAMARD_ALIGN_RND_EN
  // One extra LSB catches the most significant shifted-out bit.
  logic [MW:0]               shifted;
`endif

  always_comb begin
    aligned = '0;
    sh      = '0;
    mag     = '0;
    mag_ext = '0;
`ifdef HADAMARD_ALIGN_RND_EN
    shifted = '0;
`endif
    for (int k = 0; k < 4; k++) begin
      sh = s1_max - s1_exp[k];
`ifdef HADAMARD_ALIGN_RND_EN
      shifted = {1'b1, s1_sig[k], {low_expand{1'b0}}, 1'b0} >> sh;
      mag     = shifted[MW:1] + MW'(shifted[0]);
`else
      mag     = {1'b1, s1_sig[k], {low_expand{1'b0}}} >> sh;
`endif
      if (s1_zero[k] || (int'(sh) > MAX_SH))
        mag = '0;
      mag_ext    = {{(FW-MW){1'b0}}, mag};
      aligned[k] = s1_sgn[k] ? (~mag_ext + 1'b1) : mag_ext;
    end
  end

  logic                      s2_vld;
  logic [expWidth-1:0]       s2_max;
  logic [3:0][FW-1:0]        s2_val;

  // ---------------- S3: sum ----------------
  // Two guard bits above the magnitude width mean the 4-way sum cannot overflow.
  logic [FW-1:0]             sum_comb;
  assign sum_comb = s2_val[0] + s2_val[1] + s2_val[2] + s2_val[3];

  logic                      s3_vld;
  assign out_valid = s3_vld;

  // All stages move in lockstep; bubbles travel with the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld      <= 1'b0;
      s1_max      <= '0;
      s1_sgn      <= '0;
      s1_zero     <= '0;
      s1_exp      <= '0;
      s1_sig      <= '0;
      s2_vld      <= 1'b0;
      s2_max      <= '0;
      s2_val      <= '0;
      s3_vld      <= 1'b0;
      fix_out     <= '0;
      max_exp_out <= '0;
    end else if (advance) begin
      s1_vld      <= in_valid;
      s1_max      <= m_comb;
      s1_sgn      <= in_sgn;
      s1_zero     <= in_zero;
      s1_exp      <= in_exp;
      s1_sig      <= in_sig;
      s2_vld      <= s1_vld;
      s2_max      <= s1_max;
      s2_val      <= aligned;
      s3_vld      <= s2_vld;
      fix_out     <= sum_comb;
      max_exp_out <= s2_max;
    end
  end

endmodule

// File: tb/tb_hadamard_align_add.sv
module tb_hadamard_align_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] in_data;
  logic [3:0]  in_neg;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  fix_out;
  logic [3:0]  max_exp_out;

  always #5 clk = ~clk;

  hadamard_align_add dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_neg      (in_neg),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fix_out     (fix_out),
    .max_exp_out (max_exp_out)
  );

`ifdef HADAMARD_ALIGN_RND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] op(input bit s, input bit [3:0] e, input bit [3:0] m);
    return {s, e, m};
  endfunction

  typedef struct {
    string       name;
    logic [35:0] data;
    logic [3:0]  neg;
    logic [9:0]  fix;
    logic [3:0]  mexp;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    int cyc;
    int sent;
    int rcvd;
    bit prev_stall;
    logic [9:0] prev_fix;

    // Operand order in data: {op3, op2, op1, op0}
    vecs[0]  = '{"four_ones",   {op(0,5,0), op(0,5,0), op(0,5,0), op(0,5,0)}, 4'b0000, 10'h100, 4'd5};
    vecs[1]  = '{"cancel",      {9'd0, 9'd0, op(0,5,8), op(0,5,8)},           4'b0010, 10'h000, 4'd5};
    vecs[2]  = '{"neg_one",     {9'd0, 9'd0, 9'd0, op(1,5,0)},                4'b0000, 10'h3C0, 4'd5};
    vecs[3]  = '{"shift8_drop", {9'd0, 9'd0, op(0,1,15), op(0,9,0)},          4'b0000, 10'h040, 4'd9};
    vecs[4]  = '{"shift4",      {9'd0, 9'd0, op(0,2,15), op(0,6,0)},          4'b0000, RND ? 10'h048 : 10'h047, 4'd6};
    vecs[5]  = '{"shift7",      {9'd0, 9'd0, op(0,1,15), op(0,8,0)},          4'b0000, RND ? 10'h041 : 10'h040, 4'd8};
    vecs[6]  = '{"shift6",      {9'd0, 9'd0, op(0,1,0), op(0,7,0)},           4'b0000, 10'h041, 4'd7};
    vecs[7]  = '{"max_pos",     {op(0,3,15), op(0,3,15), op(0,3,15), op(0,3,15)}, 4'b0000, 10'h1F0, 4'd3};
    vecs[8]  = '{"max_neg",     {op(0,3,15), op(0,3,15), op(0,3,15), op(0,3,15)}, 4'b1111, 10'h210, 4'd3};
    vecs[9]  = '{"mixed",       {9'd0, op(0,2,4), op(1,4,8), op(0,4,8)},      4'b0010, 10'h0D4, 4'd4};
    vecs[10] = '{"all_zero",    36'd0,                                        4'b0101, 10'h000, 4'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_neg    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fix_out",   32'(fix_out), 0);
    chk("rst_max_exp",   32'(max_exp_out), 0);
    chk("rst_in_ready",  32'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- directed vectors ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_neg   = vecs[i].neg;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      chk({vecs[i].name, "_latency"}, 32'(cyc), 3);
      chk({vecs[i].name, "_fix"},     32'(fix_out), 32'(vecs[i].fix));
      chk({vecs[i].name, "_max_exp"}, 32'(max_exp_out), 32'(vecs[i].mexp));
    end

    // ---------------- streaming with mid-stream stall ----------------
    repeat (3) @(posedge clk);
    sent = 0;
    rcvd = 0;
    prev_stall = 1'b0;
    prev_fix = '0;
    for (int c = 0; c < 40 && rcvd < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c < 9);
      if (sent < 5) begin
        in_valid = 1'b1;
        in_data  = {27'd0, op(0, 5, 4'(sent))};
        in_neg   = 4'b0000;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk("stall_hold_fix", 32'(fix_out), 32'(prev_fix));
      if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        chk("stream_fix",     32'(fix_out), 32'(64 + 4*rcvd));
        chk("stream_max_exp", 32'(max_exp_out), 5);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_fix   = fix_out;
    end
    chk("stream_count", 32'(rcvd), 5);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    // No duplicate results once the stream has drained.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("stream_no_dup", 32'(out_valid), 0);
    end

    // ---------------- reset mid-stream ----------------
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {27'd0, op(0, 3, 1)};
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_fix_out",   32'(fix_out), 0);
    chk("reset_max_exp",   32'(max_exp_out), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_stale", 32'(out_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
